// File: rtl/bcd_scan_counter.sv
// bcd_scan_counter: four-digit up/down BCD counter with a multiplexed 7-segment scan driver
//
// Parameters:
//   SCAN_DIV  clk cycles each digit slot is held while scanning (2..65535)
// Ports:
//   clk       clock, all state updates on its rising edge
//   rst       synchronous active-high reset
//   en        count strobe, one step per high cycle
//   up_dn     count direction (1 = up, 0 = down)
//   load      synchronous load, has priority over en
//   load_val  four BCD digits to load, [3:0] is digit 0; nibbles above 9 load as 0
//   count     current four-digit BCD value
//   carry     one-cycle pulse on the cycle count shows a wrapped value
//   num       scanned BCD digit for the 7-segment decoder
//   dig_sel   one-hot digit enable, coherent with num
// Configuration:
//   BCD_SCAN_BLANK_EN  when defined, leading zero digits above digit 0 are blanked
module bcd_scan_counter #(
    parameter int unsigned SCAN_DIV = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        up_dn,
    input  logic        load,
    input  logic [15:0] load_val,
    output logic [15:0] count,
    output logic        carry,
    output logic [3:0]  num,
    output logic [3:0]  dig_sel
);
    localparam logic [15:0] PRE_MAX = 16'(SCAN_DIV - 1);

    logic [15:0] count_q, count_d;
    logic        carry_q, carry_d;
    logic [3:0]  num_q, num_d;
    logic [3:0]  dig_sel_q, dig_sel_d;
    logic [15:0] pre_q, pre_d;
    logic [1:0]  idx_q, idx_d;
    logic [15:0] inc_v, dec_v, ld_v;
    logic        all9, all0;

    // A digit steps only when every lower digit rolls over (all 9 up, all 0 down).
    always_comb begin
        inc_v = count_q;
        dec_v = count_q;
        ld_v  = load_val;
        all9  = 1'b1;
        all0  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            inc_v[4*i +: 4] = !all9 ? count_q[4*i +: 4] :
                              count_q[4*i +: 4] == 4'd9 ? 4'd0 : count_q[4*i +: 4] + 4'd1;
            dec_v[4*i +: 4] = !all0 ? count_q[4*i +: 4] :
                              count_q[4*i +: 4] == 4'd0 ? 4'd9 : count_q[4*i +: 4] - 4'd1;
            ld_v[4*i +: 4]  = load_val[4*i +: 4] > 4'd9 ? 4'd0 : load_val[4*i +: 4];
            all9 = all9 && count_q[4*i +: 4] == 4'd9;
            all0 = all0 && count_q[4*i +: 4] == 4'd0;
        end
        count_d = load ? ld_v : en ? (up_dn ? inc_v : dec_v) : count_q;
        carry_d = !load && en && (up_dn ? all9 : all0);
    end

`ifdef BCD_SCAN_BLANK_EN
    logic blank;
    // Blank a slot when its digit and every more-significant digit are zero; slot 0 always shows.
    assign blank = idx_q == 2'd3 ? count_q[15:12] == 4'd0 :
                   idx_q == 2'd2 ? count_q[15:8]  == 8'd0 :
                   idx_q == 2'd1 ? count_q[15:4]  == 12'd0 : 1'b0;
`endif

    always_comb begin
        pre_d = pre_q == PRE_MAX ? 16'd0 : pre_q + 16'd1;
        idx_d = pre_q == PRE_MAX ? idx_q + 2'd1 : idx_q;
        num_d = count_q[{idx_q, 2'b00} +: 4];
`ifdef BCD_SCAN_BLANK_EN
        dig_sel_d = blank ? 4'b0000 : 4'b0001 << idx_q;
`else
        dig_sel_d = 4'b0001 << idx_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= 16'h0000;
            carry_q   <= 1'b0;
            num_q     <= 4'd0;
            dig_sel_q <= 4'b0001;
            pre_q     <= 16'd0;
            idx_q     <= 2'd0;
        end else begin
            count_q   <= count_d;
            carry_q   <= carry_d;
            num_q     <= num_d;
            dig_sel_q <= dig_sel_d;
            pre_q     <= pre_d;
            idx_q     <= idx_d;
        end
    end

    assign count   = count_q;
    assign carry   = carry_q;
    assign num     = num_q;
    assign dig_sel = dig_sel_q;
endmodule

// File: tb/tb_bcd_scan_counter.sv
// tb_bcd_scan_counter: directed self-checking bench for bcd_scan_counter
module tb_bcd_scan_counter;
    logic        clk = 1'b0;
    logic        rst, en, up_dn, load;
    logic [15:0] load_val, count;
    logic        carry;
    logic [3:0]  num, dig_sel, prev;
    logic        found;
    int          tests = 0;
    int          fails = 0;

    bcd_scan_counter #(.SCAN_DIV(4)) dut (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .count(count), .carry(carry), .num(num), .dig_sel(dig_sel)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_load(input logic [15:0] v);
        load = 1'b1; en = 1'b0; load_val = v;
        step();
        load = 1'b0;
    endtask

    task automatic align();
        prev  = dig_sel;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            step();
            found = prev != 4'b0001 && dig_sel == 4'b0001;
            prev  = dig_sel;
        end
        chk("scan_align", 16'(found), 16'd1);
    endtask

    task automatic scan_check(input string tag, input logic [15:0] nums, input logic [15:0] sels);
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 4; c++) begin
                chk({tag, "_num"}, 16'(num), 16'(nums[4*s +: 4]));
                chk({tag, "_sel"}, 16'(dig_sel), 16'(sels[4*s +: 4]));
                step();
            end
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; up_dn = 1'b1; load = 1'b1; load_val = 16'h1234;
        step();
        step();
        chk("rst_count", count, 16'h0000);
        chk("rst_carry", 16'(carry), 16'd0);
        chk("rst_sel", 16'(dig_sel), 16'h0001);
        chk("rst_num", 16'(num), 16'd0);

        rst = 1'b0; load = 1'b1; en = 1'b0; load_val = 16'h9998;
        step();
        chk("first_load", count, 16'h9998);
        load = 1'b0; en = 1'b1; up_dn = 1'b1;
        step();
        chk("up_9999", count, 16'h9999);
        chk("up_9999_carry", 16'(carry), 16'd0);
        step();
        chk("up_wrap", count, 16'h0000);
        chk("up_wrap_carry", 16'(carry), 16'd1);
        en = 1'b0;
        step();
        chk("idle_carry", 16'(carry), 16'd0);

        do_load(16'h0001);
        chk("load_0001", count, 16'h0001);
        en = 1'b1; up_dn = 1'b0;
        step();
        chk("dn_0000", count, 16'h0000);
        chk("dn_0000_carry", 16'(carry), 16'd0);
        step();
        chk("dn_wrap", count, 16'h9999);
        chk("dn_wrap_carry", 16'(carry), 16'd1);

        load = 1'b1; en = 1'b1; up_dn = 1'b1; load_val = 16'h3A5F;
        step();
        chk("clamp", count, 16'h3050);
        chk("clamp_carry", 16'(carry), 16'd0);
        load_val = 16'h9999;
        step();
        chk("load_9999", count, 16'h9999);
        chk("load_no_carry", 16'(carry), 16'd0);

        do_load(16'h0199);
        en = 1'b1; up_dn = 1'b1;
        step();
        chk("inc_ripple", count, 16'h0200);
        up_dn = 1'b0;
        step();
        chk("dec_ripple", count, 16'h0199);
        step();
        chk("dec_plain", count, 16'h0198);

        do_load(16'h9999);
        en = 1'b1; up_dn = 1'b1; rst = 1'b1;
        step();
        chk("rst_mid_count", count, 16'h0000);
        chk("rst_mid_carry", 16'(carry), 16'd0);
        rst = 1'b0; en = 1'b0;

        do_load(16'h1234);
        step();
        step();
        align();
        scan_check("scan1234", 16'h1234, 16'h8421);

        do_load(16'h0050);
        step();
        step();
        align();
`ifdef BCD_SCAN_BLANK_EN
        scan_check("blank0050", 16'h0050, 16'h0021);
`else
        scan_check("noblank0050", 16'h0050, 16'h8421);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
